jtkcpu_intsched: RTL

Interrupt scheduler for the KCPU core. Samples the NMI/FIRQ/IRQ pins and the HALT request, applies CC masking and priority, and raises one service request at a time to the microcode sequencer at instruction boundaries. It also provides the vector nibble and the stack-frame type, and handles SYNC/CWAI wait states. It sits between the pins and the microcode, next to the control unit that updates the PC.

---
 rtl/jtkcpu_intsched_pkg.sv | 51 +++++
 rtl/jtkcpu_intsync.sv | 84 ++++++++
 rtl/jtkcpu_intsched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/jtkcpu_intsched_pkg.sv
// Shared definitions for the KCPU interrupt scheduler: vector nibbles,
// CC bit positions, scheduler state and service-kind encodings, and
// helpers that map a service kind to its frame attributes.
package jtkcpu_intsched_pkg;

    // Vector low nibbles
    localparam logic [3:0] VEC_RST  = 4'hE;
    localparam logic [3:0] VEC_NMI  = 4'hC;
    localparam logic [3:0] VEC_FIRQ = 4'h6;
    localparam logic [3:0] VEC_IRQ  = 4'h8;

    // Condition-code mask bits
    localparam int CC_F = 6;
    localparam int CC_I = 4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_RST  = 2'd0,
        K_NMI  = 2'd1,
        K_FIRQ = 2'd2,
        K_IRQ  = 2'd3
    } kind_t;

    function automatic logic [3:0] kind_vec(input kind_t k);
        logic [3:0] v;
        case (k)
            K_RST:   v = VEC_RST;
            K_NMI:   v = VEC_NMI;
            K_FIRQ:  v = VEC_FIRQ;
            default: v = VEC_IRQ;
        endcase
        return v;
    endfunction

    // Entire-state frame for NMI and IRQ; reset and FIRQ push PC+CC only
    function automatic logic kind_psh(input kind_t k);
        return (k == K_NMI) || (k == K_IRQ);
    endfunction

    // F is set on every entry except IRQ
    function automatic logic kind_setf(input kind_t k);
        return (k != K_IRQ);
    endfunction

endpackage

// File: rtl/jtkcpu_intsync.sv
// Pin sampling for the interrupt scheduler: registers nmi/firq/irq on cen,
// detects the NMI rising edge, keeps the NMI pending flag and the NMI arm.
// Optional feature macro: JTKCPU_NMI_ARM_EN (NMI disarmed until first S write).
module jtkcpu_intsync (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic nmi,
    input  logic firq,
    input  logic irq,
    input  logic s_wr,
    input  logic nmi_clr,
    output logic nmi_el,
    output logic firq_s,
    output logic irq_s,
    output logic line_act
);

    logic r_nmi_s;
    logic r_nmi_prev;
    logic r_firq_s;
    logic r_irq_s;
    logic r_nmi_pend;
    logic w_armed;
    logic w_nmi_edge;

`ifdef JTKCPU_NMI_ARM_EN
    logic r_armed;

    // NMI is armed by the first write to S and stays armed until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (cen && s_wr) begin
            r_armed <= 1'b1;
        end
    end

    assign w_armed = r_armed;
`else
    logic w_unused_s_wr;
    assign w_unused_s_wr = s_wr;
    assign w_armed       = 1'b1;
`endif

    assign w_nmi_edge = r_nmi_s & ~r_nmi_prev;

    // Sampling registers; the previous NMI sample only moves with cen so
    // edge detection freezes while the core is clock-gated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_s    <= 1'b0;
            r_nmi_prev <= 1'b0;
            r_firq_s   <= 1'b0;
            r_irq_s    <= 1'b0;
        end else if (cen) begin
            r_nmi_s    <= nmi;
            r_nmi_prev <= r_nmi_s;
            r_firq_s   <= firq;
            r_irq_s    <= irq;
        end
    end

    // Pending NMI: an armed edge sets it (wins over a same-cycle clear),
    // acknowledging an NMI request clears it; unarmed edges are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_pend <= 1'b0;
        end else if (cen) begin
            if (w_nmi_edge && w_armed) begin
                r_nmi_pend <= 1'b1;
            end else if (nmi_clr) begin
                r_nmi_pend <= 1'b0;
            end
        end
    end

    // A fresh edge is eligible in the same cycle it is detected
    assign nmi_el   = w_armed & (r_nmi_pend | w_nmi_edge);
    assign firq_s   = r_firq_s;
    assign irq_s    = r_irq_s;
    assign line_act = w_nmi_edge | r_firq_s | r_irq_s;

endmodule

// File: rtl/jtkcpu_intsched.sv
// KCPU interrupt scheduler: prioritises reset/NMI/FIRQ/IRQ against the CC
// masks and raises one service request at a time at instruction boundaries.
// Also handles HALT and the SYNC/CWAI wait states.
// Optional feature macro: JTKCPU_NMI_ARM_EN (see jtkcpu_intsync).
//
// Handshake: int_req rises at a boundary (ni) and stays high with a frozen
// intvec/psh_all/set_i/set_f until int_ack is seen on a cen cycle; int_req
// then drops on the following cen cycle. int_ack outside REQ is ignored.
module jtkcpu_intsched
    import jtkcpu_intsched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       nmi,
    input  logic       firq,
    input  logic       irq,
    input  logic       halt,
    input  logic [7:0] cc,
    input  logic       ni,
    input  logic       int_ack,
    input  logic       sync_wait,
    input  logic       cwai_wait,
    input  logic       s_wr,
    output logic       int_req,
    output logic [3:0] intvec,
    output logic       psh_all,
    output logic       set_i,
    output logic       set_f,
    output logic       stall,
    output logic [1:0] dbg_state
);

    state_t     r_state;
    kind_t      r_kind;
    logic       r_cwai;
    logic       r_reset_pend;
    logic       r_int_req;
    logic [3:0] r_intvec;
    logic       r_psh_all;
    logic       r_set_i;
    logic       r_set_f;
    logic       r_stall;

    logic  w_nmi_el;
    logic  w_firq_s;
    logic  w_irq_s;
    logic  w_line_act;
    logic  w_nmi_clr;
    logic  w_firq_el;
    logic  w_irq_el;
    logic  w_any_el;
    kind_t w_win;
    logic  w_unused_cc;

    assign w_unused_cc = ^{cc[7], cc[5], cc[3:0]};

    assign w_nmi_clr = (r_state == ST_REQ) && int_ack && (r_kind == K_NMI);

    jtkcpu_intsync u_sync (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .nmi      (nmi),
        .firq     (firq),
        .irq      (irq),
        .s_wr     (s_wr),
        .nmi_clr  (w_nmi_clr),
        .nmi_el   (w_nmi_el),
        .firq_s   (w_firq_s),
        .irq_s    (w_irq_s),
        .line_act (w_line_act)
    );

    assign w_firq_el = w_firq_s & ~cc[CC_F];
    assign w_irq_el  = w_irq_s & ~cc[CC_I];
    assign w_any_el  = r_reset_pend | w_nmi_el | w_firq_el | w_irq_el;

    // Fixed priority: reset > NMI > FIRQ > IRQ
    always_comb begin
        w_win = K_IRQ;
        if (r_reset_pend) begin
            w_win = K_RST;
        end else if (w_nmi_el) begin
            w_win = K_NMI;
        end else if (w_firq_el) begin
            w_win = K_FIRQ;
        end
    end

    // Scheduler FSM with registered request/frame/stall outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_kind       <= K_RST;
            r_cwai       <= 1'b0;
            r_reset_pend <= 1'b1;
            r_int_req    <= 1'b0;
            r_intvec     <= VEC_RST;
            r_psh_all    <= 1'b0;
            r_set_i      <= 1'b0;
            r_set_f      <= 1'b0;
            r_stall      <= 1'b0;
        end else if (cen) begin
            case (r_state)
                ST_RUN: begin
                    // Halt wins over an interrupt at the same boundary
                    if (ni && halt) begin
                        r_state <= ST_HALT;
                        r_stall <= 1'b1;
                    end else if (ni && w_any_el) begin
                        r_state   <= ST_REQ;
                        r_kind    <= w_win;
                        r_int_req <= 1'b1;
                        r_intvec  <= kind_vec(w_win);
                        r_psh_all <= kind_psh(w_win);
                        r_set_i   <= 1'b1;
                        r_set_f   <= kind_setf(w_win);
                    end else if (sync_wait || cwai_wait) begin
                        r_state <= ST_WAIT;
                        r_cwai  <= cwai_wait;
                        r_stall <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Kind is frozen here; only the ack moves us on
                    if (int_ack) begin
                        r_state   <= ST_RUN;
                        r_int_req <= 1'b0;
                        if (r_kind == K_RST) begin
                            r_reset_pend <= 1'b0;
                        end
                    end
                end
                ST_HALT: begin
                    if (!halt) begin
                        r_state <= ST_RUN;
                        r_stall <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_cwai) begin
                        // State is already stacked, so the frame is short
                        if (w_any_el) begin
                            r_state   <= ST_REQ;
                            r_kind    <= w_win;
                            r_int_req <= 1'b1;
                            r_intvec  <= kind_vec(w_win);
                            r_psh_all <= 1'b0;
                            r_set_i   <= 1'b1;
                            r_set_f   <= kind_setf(w_win);
                            r_stall   <= 1'b0;
                        end
                    end else if (w_line_act) begin
                        // SYNC resumes on any line activity, masked or not
                        r_state <= ST_RUN;
                        r_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign int_req   = r_int_req;
    assign intvec    = r_intvec;
    assign psh_all   = r_psh_all;
    assign set_i     = r_set_i;
    assign set_f     = r_set_f;
    assign stall     = r_stall;
    assign dbg_state = r_state;

endmodule
